// File: rtl/mem_responder.sv
// Memory-side responder: latches a Read/Write request, waits WAIT_CYCLES, performs
// the RAM access and returns a one-cycle Done (plus Error for Read+Write requests).
//
// state  | meaning
// IDLE   | waiting for Read or Write; operands latched on acceptance
// WAIT   | counting down programmable wait states
// ACCESS | RAM write or ReadData load happens on the exiting edge
// DONE   | Done (and Error, if illegal) high for this cycle
// HOLD   | strobe still high after Done; wait for it to drop before re-arming
module mem_responder #(
   parameter int ADDR_WIDTH  = 9,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Read,
   input  logic                  Write,
   input  logic [ADDR_WIDTH-1:0] Address,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  Done,
   output logic                  Busy,
   output logic                  Error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_DONE,
      S_HOLD
   } state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t                state;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  op_rd;
   logic                  op_wr;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // RAM is deliberately not reset; an aborted write never reaches ACCESS
   always_ff @(posedge Clock) begin
      if (state == S_ACCESS && op_wr && !op_rd)
         mem[addr_q] <= data_q;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         op_rd    <= 1'b0;
         op_wr    <= 1'b0;
         ReadData <= '0;
         Done     <= 1'b0;
         Busy     <= 1'b0;
         Error    <= 1'b0;
      end else begin
         Done  <= 1'b0;
         Error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Read || Write) begin
                  addr_q <= Address;
                  data_q <= WriteData;
                  op_rd  <= Read;
                  op_wr  <= Write;
                  cnt    <= WAIT_LD;
                  Busy   <= 1'b1;
                  state  <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= S_ACCESS;
            end
            S_ACCESS: begin
               if (op_rd && !op_wr)
                  ReadData <= mem[addr_q];
               Done  <= 1'b1;
               Error <= op_rd && op_wr;
               state <= S_DONE;
            end
            S_DONE: begin
               if (Read || Write) begin
                  state <= S_HOLD;
               end else begin
                  state <= S_IDLE;
                  Busy  <= 1'b0;
               end
            end
            S_HOLD: begin
               if (!Read && !Write) begin
                  state <= S_IDLE;
                  Busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table on a W=1 instance plus hand-written
// sequences for held strobes, latched operands, reset abort and a W=0 instance.
module tb_mem_responder;

   logic        Clock;
   logic        Reset;
   logic        r0, w0, r1, w1;
   logic [8:0]  a0, a1;
   logic [31:0] wd0, wd1, rd0, rd1;
   logic        d0, b0, e0, d1, b1, e1;

   int n_cmp = 0;
   int n_err = 0;

   mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_CYCLES(1)) u_w1 (
      .Clock(Clock), .Reset(Reset), .Read(r0), .Write(w0), .Address(a0),
      .WriteData(wd0), .ReadData(rd0), .Done(d0), .Busy(b0), .Error(e0));

   mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_CYCLES(0)) u_w0 (
      .Clock(Clock), .Reset(Reset), .Read(r1), .Write(w1), .Address(a1),
      .WriteData(wd1), .ReadData(rd1), .Done(d1), .Busy(b1), .Error(e1));

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [8:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic rd, input logic wr,
                        input logic [8:0] a, input logic [31:0] wd);
      if (sel == 0) begin r0 = rd; w0 = wr; a0 = a; wd0 = wd; end
      else          begin r1 = rd; w1 = wr; a1 = a; wd1 = wd; end
   endtask

   function automatic logic done_of(input int sel);
      return (sel == 0) ? d0 : d1;
   endfunction

   // Issue one request, return latency from accept edge to Done, captured outputs,
   // whether Done was a single-cycle pulse, and the time of the accept edge.
   task automatic req(input int sel, input logic rd, input logic wr,
                      input logic [8:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rdv, output logic errv,
                      output logic one_pulse, output time acc_t);
      drive(sel, rd, wr, a, wd);
      @(posedge Clock);
      acc_t = $time;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge Clock); #1;
         if (done_of(sel)) begin
            lat = k;
            break;
         end
      end
      rdv  = (sel == 0) ? rd0 : rd1;
      errv = (sel == 0) ? e0 : e1;
      drive(sel, 1'b0, 1'b0, a, wd);
      @(posedge Clock); #1;
      one_pulse = !done_of(sel);
   endtask

   int          lat;
   logic [31:0] rdv;
   logic        errv, onep;
   time         t_a, t_b;
   int          n_done;

   initial begin
      vt[0] = '{1'b0, 1'b1, 9'h00A, 32'hDEADBEEF, 32'h00000000, 1'b0};
      vt[1] = '{1'b1, 1'b0, 9'h00A, 32'h00000000, 32'hDEADBEEF, 1'b0};
      vt[2] = '{1'b0, 1'b1, 9'h003, 32'h00000055, 32'hDEADBEEF, 1'b0};
      vt[3] = '{1'b0, 1'b1, 9'h1FF, 32'h12345678, 32'hDEADBEEF, 1'b0};
      vt[4] = '{1'b0, 1'b1, 9'h021, 32'h0BADF00D, 32'hDEADBEEF, 1'b0};
      vt[5] = '{1'b0, 1'b1, 9'h005, 32'h5A5A0005, 32'hDEADBEEF, 1'b0};
      vt[6] = '{1'b1, 1'b0, 9'h003, 32'h00000000, 32'h00000055, 1'b0};
      vt[7] = '{1'b1, 1'b1, 9'h003, 32'hFFFFFFFF, 32'h00000055, 1'b1};
      vt[8] = '{1'b1, 1'b0, 9'h003, 32'h00000000, 32'h00000055, 1'b0};

      drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 9'h0, 32'h0);
      Reset = 1'b0;
      #1 Reset = 1'b1;
      #2;
      chk("reset_done",  {31'b0, d0}, 32'h0);
      chk("reset_busy",  {31'b0, b0}, 32'h0);
      chk("reset_error", {31'b0, e0}, 32'h0);
      chk("reset_rdata", rd0, 32'h0);
      #19 Reset = 1'b0;
      @(posedge Clock); #1;

      for (int i = 0; i < 9; i++) begin
         req(0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, lat, rdv, errv, onep, t_a);
         chk($sformatf("vec%0d_latency", i), lat, 32'd2);
         chk($sformatf("vec%0d_pulse", i), {31'b0, onep}, 32'h1);
         chk($sformatf("vec%0d_rdata", i), rdv, vt[i].exp_rdata);
         chk($sformatf("vec%0d_error", i), {31'b0, errv}, {31'b0, vt[i].exp_err});
      end

      // Held strobe: Read high for 10 cycles after acceptance
      drive(0, 1'b1, 1'b0, 9'h1FF, 32'h0);
      @(posedge Clock);
      n_done = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge Clock); #1;
         if (d0) n_done++;
      end
      chk("held_done_count", n_done, 32'd1);
      chk("held_busy_in_hold", {31'b0, b0}, 32'h1);
      chk("held_rdata", rd0, 32'h12345678);
      drive(0, 1'b0, 1'b0, 9'h1FF, 32'h0);
      @(posedge Clock); #1;
      chk("held_busy_released", {31'b0, b0}, 32'h0);

      // Latched operands: change Address/WriteData during WAIT
      drive(0, 1'b0, 1'b1, 9'h020, 32'hA5A5A5A5);
      @(posedge Clock); #1;
      a0  = 9'h021;
      wd0 = 32'h0;
      for (int k = 0; k < 20 && !d0; k++) begin
         @(posedge Clock); #1;
      end
      chk("latched_done_seen", {31'b0, d0}, 32'h1);
      drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
      @(posedge Clock); #1;
      req(0, 1'b1, 1'b0, 9'h020, 32'h0, lat, rdv, errv, onep, t_a);
      chk("latched_ram20", rdv, 32'hA5A5A5A5);
      req(0, 1'b1, 1'b0, 9'h021, 32'h0, lat, rdv, errv, onep, t_a);
      chk("latched_ram21", rdv, 32'h0BADF00D);

      // Reset abort during WAIT of a write to 0x005
      drive(0, 1'b0, 1'b1, 9'h005, 32'hFFFFFFFF);
      @(posedge Clock); #1;
      chk("abort_busy_before", {31'b0, b0}, 32'h1);
      #2 Reset = 1'b1;
      #1;
      chk("abort_busy",  {31'b0, b0}, 32'h0);
      chk("abort_done",  {31'b0, d0}, 32'h0);
      chk("abort_error", {31'b0, e0}, 32'h0);
      chk("abort_rdata", rd0, 32'h0);
      drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
      #3 Reset = 1'b0;
      n_done = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge Clock); #1;
         if (d0) n_done++;
      end
      chk("abort_no_done", n_done, 32'd0);
      req(0, 1'b1, 1'b0, 9'h005, 32'h0, lat, rdv, errv, onep, t_a);
      chk("abort_ram5", rdv, 32'h5A5A0005);

      // Zero wait states on the second instance
      req(1, 1'b0, 1'b1, 9'h000, 32'h11111111, lat, rdv, errv, onep, t_a);
      req(1, 1'b0, 1'b1, 9'h001, 32'h22222222, lat, rdv, errv, onep, t_a);
      req(1, 1'b1, 1'b0, 9'h000, 32'h0, lat, rdv, errv, onep, t_a);
      chk("w0_rd0_latency", lat, 32'd1);
      chk("w0_rd0_rdata", rdv, 32'h11111111);
      chk("w0_rd0_pulse", {31'b0, onep}, 32'h1);
      req(1, 1'b1, 1'b0, 9'h001, 32'h0, lat, rdv, errv, onep, t_b);
      chk("w0_rd1_latency", lat, 32'd1);
      chk("w0_rd1_rdata", rdv, 32'h22222222);
      chk("w0_spacing_cycles", 32'((t_b - t_a) / 10), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
